// File: rtl/axi_ad9959_regbank.sv
// AXI4-Lite register bank for the AD9959 engine: R/W control regs, RO status regs, write pulses, SLVERR decode.
// Optional shadow/commit staging of the control regs is enabled by defining AD9959_REGBANK_SHADOW_EN.
module axi_ad9959_regbank #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6,
  parameter int NUM_CTRL   = 8,
  parameter int NUM_STAT   = 4
) (
  input  logic                           ACLK,
  input  logic                           ARESETN,
  input  logic [ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic                           S_AXI_AWVALID,
  output logic                           S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                           S_AXI_WVALID,
  output logic                           S_AXI_WREADY,
  output logic [1:0]                     S_AXI_BRESP,
  output logic                           S_AXI_BVALID,
  input  logic                           S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic                           S_AXI_ARVALID,
  output logic                           S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                     S_AXI_RRESP,
  output logic                           S_AXI_RVALID,
  input  logic                           S_AXI_RREADY,
  output logic [NUM_CTRL*DATA_WIDTH-1:0] ctrl_regs,
  output logic [NUM_CTRL-1:0]            ctrl_wr_pulse,
  input  logic [NUM_STAT*DATA_WIDTH-1:0] stat_in
`ifdef AD9959_REGBANK_SHADOW_EN
  ,
  input  logic                           commit
`endif
);

  localparam int IDX_W    = ADDR_WIDTH - 2;
  localparam int NUM_REGS = NUM_CTRL + NUM_STAT;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  generate
    if (DATA_WIDTH != 32 || NUM_REGS > 2**IDX_W) begin : g_bad_params
      $error("axi_ad9959_regbank: DATA_WIDTH must be 32 and the register map must fit the address space");
    end
  endgenerate

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_RESP} r_state_t;

  w_state_t                w_state;
  r_state_t                r_state;
  logic                    aw_cap;
  logic                    w_cap;
  logic [IDX_W-1:0]        wr_idx;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic [DATA_WIDTH/8-1:0] wr_strb;
  logic                    wr_fire;
  logic [NUM_CTRL-1:0]     pulse_next;
  logic [DATA_WIDTH-1:0]   store      [NUM_CTRL];
  logic [DATA_WIDTH-1:0]   store_next [NUM_CTRL];
  logic [IDX_W-1:0]        rd_idx;
  logic [DATA_WIDTH-1:0]   rd_data_next;
  logic [1:0]              rd_resp_next;
  logic                    unused_addr_bits;

  // Byte-lane offsets are architecturally ignored; accesses are always word aligned.
  assign unused_addr_bits = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign wr_fire = (w_state == W_IDLE) && aw_cap && w_cap;
  assign rd_idx  = S_AXI_ARADDR[ADDR_WIDTH-1:2];

  always_comb begin
    store_next = store;
    pulse_next = '0;
    for (int i = 0; i < NUM_CTRL; i++) begin
      if (wr_fire && wr_idx == IDX_W'(i)) begin
        pulse_next[i] = 1'b1;
        for (int b = 0; b < DATA_WIDTH/8; b++) begin
          if (wr_strb[b]) store_next[i][8*b +: 8] = wr_data[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      w_state       <= W_IDLE;
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY  <= 1'b0;
      S_AXI_BVALID  <= 1'b0;
      S_AXI_BRESP   <= RESP_OKAY;
      aw_cap        <= 1'b0;
      w_cap         <= 1'b0;
      wr_idx        <= '0;
      wr_data       <= '0;
      wr_strb       <= '0;
      ctrl_wr_pulse <= '0;
    end else begin
      ctrl_wr_pulse <= pulse_next;
      case (w_state)
        W_IDLE: begin
          if (wr_fire) begin
            S_AXI_BVALID <= 1'b1;
            S_AXI_BRESP  <= (|pulse_next) ? RESP_OKAY : RESP_SLVERR;
            aw_cap       <= 1'b0;
            w_cap        <= 1'b0;
            w_state      <= W_RESP;
          end else begin
            // Each channel is captured independently and its ready drops until the response completes.
            if (S_AXI_AWREADY && S_AXI_AWVALID) begin
              wr_idx <= S_AXI_AWADDR[ADDR_WIDTH-1:2];
              aw_cap <= 1'b1;
            end
            if (S_AXI_WREADY && S_AXI_WVALID) begin
              wr_data <= S_AXI_WDATA;
              wr_strb <= S_AXI_WSTRB;
              w_cap   <= 1'b1;
            end
            S_AXI_AWREADY <= !(aw_cap || (S_AXI_AWREADY && S_AXI_AWVALID));
            S_AXI_WREADY  <= !(w_cap || (S_AXI_WREADY && S_AXI_WVALID));
          end
        end
        W_RESP: begin
          if (S_AXI_BREADY) begin
            S_AXI_BVALID  <= 1'b0;
            S_AXI_AWREADY <= 1'b1;
            S_AXI_WREADY  <= 1'b1;
            w_state       <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < NUM_CTRL; i++) store[i] <= '0;
    end else begin
      store <= store_next;
    end
  end

`ifdef AD9959_REGBANK_SHADOW_EN
  logic [DATA_WIDTH-1:0] live [NUM_CTRL];

  // Committing from store_next lets a write landing on the commit edge go straight through.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < NUM_CTRL; i++) live[i] <= '0;
    end else if (commit) begin
      live <= store_next;
    end
  end

  for (genvar g = 0; g < NUM_CTRL; g++) begin : g_ctrl_out
    assign ctrl_regs[DATA_WIDTH*g +: DATA_WIDTH] = live[g];
  end
`else
  for (genvar g = 0; g < NUM_CTRL; g++) begin : g_ctrl_out
    assign ctrl_regs[DATA_WIDTH*g +: DATA_WIDTH] = store[g];
  end
`endif

  always_comb begin
    rd_data_next = '0;
    rd_resp_next = RESP_SLVERR;
    for (int i = 0; i < NUM_CTRL; i++) begin
      if (rd_idx == IDX_W'(i)) begin
        rd_data_next = store[i];
        rd_resp_next = RESP_OKAY;
      end
    end
    for (int j = 0; j < NUM_STAT; j++) begin
      if (rd_idx == IDX_W'(NUM_CTRL + j)) begin
        rd_data_next = stat_in[DATA_WIDTH*j +: DATA_WIDTH];
        rd_resp_next = RESP_OKAY;
      end
    end
  end

  // Read data is captured at the AR handshake, so a same-edge write is not yet visible.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state       <= R_IDLE;
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RRESP   <= RESP_OKAY;
      S_AXI_RDATA   <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (S_AXI_ARREADY && S_AXI_ARVALID) begin
            S_AXI_RDATA   <= rd_data_next;
            S_AXI_RRESP   <= rd_resp_next;
            S_AXI_RVALID  <= 1'b1;
            S_AXI_ARREADY <= 1'b0;
            r_state       <= R_RESP;
          end else begin
            S_AXI_ARREADY <= 1'b1;
          end
        end
        R_RESP: begin
          if (S_AXI_RREADY) begin
            S_AXI_RVALID  <= 1'b0;
            S_AXI_ARREADY <= 1'b1;
            r_state       <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_ad9959_regbank.sv
// Self-checking bench for axi_ad9959_regbank: vector table, directed corner sequences and a randomized
// phase checked against a register-map model. Shadow/commit checks build when AD9959_REGBANK_SHADOW_EN is defined.
module tb_axi_ad9959_regbank;
  localparam int NC = 8;
  localparam int NS = 4;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b1;
  logic [5:0]           s_axi_awaddr = '0;
  logic                 s_axi_awvalid = 1'b0;
  logic                 s_axi_awready;
  logic [31:0]          s_axi_wdata = '0;
  logic [3:0]           s_axi_wstrb = '0;
  logic                 s_axi_wvalid = 1'b0;
  logic                 s_axi_wready;
  logic [1:0]           s_axi_bresp;
  logic                 s_axi_bvalid;
  logic                 s_axi_bready = 1'b0;
  logic [5:0]           s_axi_araddr = '0;
  logic                 s_axi_arvalid = 1'b0;
  logic                 s_axi_arready;
  logic [31:0]          s_axi_rdata;
  logic [1:0]           s_axi_rresp;
  logic                 s_axi_rvalid;
  logic                 s_axi_rready = 1'b0;
  logic [NC*32-1:0]     ctrl_regs;
  logic [NC-1:0]        ctrl_wr_pulse;
  logic [NS*32-1:0]     stat_in = '0;
`ifdef AD9959_REGBANK_SHADOW_EN
  logic                 commit = 1'b0;
`endif

  always #5 clk = ~clk;

  axi_ad9959_regbank dut (
    .ACLK(clk),
    .ARESETN(rst_n),
    .S_AXI_AWADDR(s_axi_awaddr),
    .S_AXI_AWVALID(s_axi_awvalid),
    .S_AXI_AWREADY(s_axi_awready),
    .S_AXI_WDATA(s_axi_wdata),
    .S_AXI_WSTRB(s_axi_wstrb),
    .S_AXI_WVALID(s_axi_wvalid),
    .S_AXI_WREADY(s_axi_wready),
    .S_AXI_BRESP(s_axi_bresp),
    .S_AXI_BVALID(s_axi_bvalid),
    .S_AXI_BREADY(s_axi_bready),
    .S_AXI_ARADDR(s_axi_araddr),
    .S_AXI_ARVALID(s_axi_arvalid),
    .S_AXI_ARREADY(s_axi_arready),
    .S_AXI_RDATA(s_axi_rdata),
    .S_AXI_RRESP(s_axi_rresp),
    .S_AXI_RVALID(s_axi_rvalid),
    .S_AXI_RREADY(s_axi_rready),
    .ctrl_regs(ctrl_regs),
    .ctrl_wr_pulse(ctrl_wr_pulse),
    .stat_in(stat_in)
`ifdef AD9959_REGBANK_SHADOW_EN
    ,
    .commit(commit)
`endif
  );

  typedef struct {
    bit          is_write;
    int          idx;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] m_shadow [NC];
  logic [31:0] m_live   [NC];
  logic [31:0] m_stat   [NS];
  int          pulse_cnt [NC];

  always @(negedge clk) begin
    for (int i = 0; i < NC; i++) if (ctrl_wr_pulse[i]) pulse_cnt[i]++;
  end

  task automatic check_output(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Register-map model: byte-masked merge into ctrl, live follows shadow unless staging is enabled.
  task automatic model_write(input int idx, input logic [31:0] data, input logic [3:0] strb);
    logic [31:0] mask;
    for (int b = 0; b < 4; b++) mask[8*b +: 8] = {8{strb[b]}};
    if (idx < NC) m_shadow[idx] = (m_shadow[idx] & ~mask) | (data & mask);
`ifdef AD9959_REGBANK_SHADOW_EN
    if (commit) m_live = m_shadow;
`else
    m_live = m_shadow;
`endif
  endtask

  task automatic model_read(input int idx, output logic [31:0] data, output logic [1:0] resp);
    if (idx < NC) begin
      data = m_shadow[idx]; resp = 2'b00;
    end else if (idx < NC + NS) begin
      data = m_stat[idx - NC]; resp = 2'b00;
    end else begin
      data = 32'h0; resp = 2'b10;
    end
  endtask

  function automatic logic [NC*32-1:0] live_flat();
    logic [NC*32-1:0] f;
    for (int i = 0; i < NC; i++) f[32*i +: 32] = m_live[i];
    return f;
  endfunction

  function automatic int pulse_total();
    int s = 0;
    for (int i = 0; i < NC; i++) s += pulse_cnt[i];
    return s;
  endfunction

  task automatic push_stat();
    for (int j = 0; j < NS; j++) stat_in[32*j +: 32] = m_stat[j];
  endtask

  task automatic model_reset();
    for (int i = 0; i < NC; i++) begin m_shadow[i] = '0; m_live[i] = '0; end
  endtask

  // All bus tasks start and end 1 time unit after a rising edge.
  task automatic axi_write(input int idx, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, output logic [1:0] resp, output bit ok);
    int cyc;
    bit aw_done, w_done, aw_fire, w_fire;
    aw_done = 0; w_done = 0; cyc = 0; ok = 1; resp = 2'b11;
    s_axi_awaddr = 6'((idx << 2) | int'($urandom_range(0, 3)));
    s_axi_wdata  = data;
    s_axi_wstrb  = strb;
    while (!(aw_done && w_done) && cyc < 64) begin
      s_axi_awvalid = !aw_done && cyc >= aw_dly;
      s_axi_wvalid  = !w_done && cyc >= w_dly;
      aw_fire = s_axi_awvalid && s_axi_awready;
      w_fire  = s_axi_wvalid && s_axi_wready;
      @(posedge clk); #1;
      if (aw_fire) aw_done = 1;
      if (w_fire)  w_done = 1;
      cyc++;
    end
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
    if (!(aw_done && w_done)) ok = 0;
    s_axi_bready = 1'b1;
    cyc = 0;
    while (ok && !s_axi_bvalid && cyc < 64) begin @(posedge clk); #1; cyc++; end
    if (ok && s_axi_bvalid) begin
      resp = s_axi_bresp;
      @(posedge clk); #1;
    end else ok = 0;
    s_axi_bready = 1'b0;
  endtask

  task automatic axi_read(input int idx, output logic [31:0] data, output logic [1:0] resp, output bit ok);
    int cyc;
    bit fire;
    ok = 0; cyc = 0; data = 'x; resp = 2'b11;
    s_axi_araddr  = 6'((idx << 2) | int'($urandom_range(0, 3)));
    s_axi_arvalid = 1'b1;
    while (!ok && cyc < 64) begin
      fire = s_axi_arready;
      @(posedge clk); #1;
      if (fire) ok = 1;
      cyc++;
    end
    s_axi_arvalid = 1'b0;
    s_axi_rready  = 1'b1;
    cyc = 0;
    while (ok && !s_axi_rvalid && cyc < 64) begin @(posedge clk); #1; cyc++; end
    if (ok && s_axi_rvalid) begin
      data = s_axi_rdata;
      resp = s_axi_rresp;
      @(posedge clk); #1;
    end else ok = 0;
    s_axi_rready = 1'b0;
  endtask

  task automatic do_write(input string name, input int idx, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, input logic [1:0] exp_resp);
    logic [1:0] resp;
    bit ok;
    int tot0, bit0;
    tot0 = pulse_total();
    bit0 = (idx < NC) ? pulse_cnt[idx] : 0;
    axi_write(idx, data, strb, aw_dly, w_dly, resp, ok);
    model_write(idx, data, strb);
    check_output({name, "_done"}, 256'(ok), 256'(1));
    check_output({name, "_bresp"}, 256'(resp), 256'(exp_resp));
    check_output({name, "_pulses"}, 256'(pulse_total() - tot0), 256'((idx < NC) ? 1 : 0));
    if (idx < NC) check_output({name, "_pulse_bit"}, 256'(pulse_cnt[idx] - bit0), 256'(1));
    check_output({name, "_ctrl_regs"}, 256'(ctrl_regs), 256'(live_flat()));
  endtask

  task automatic do_read(input string name, input int idx, input logic [31:0] exp_data, input logic [1:0] exp_resp);
    logic [31:0] data;
    logic [1:0]  resp;
    bit ok;
    axi_read(idx, data, resp, ok);
    check_output({name, "_done"}, 256'(ok), 256'(1));
    check_output({name, "_rdata"}, 256'(data), 256'(exp_data));
    check_output({name, "_rresp"}, 256'(resp), 256'(exp_resp));
  endtask

  initial begin
    vec_t        vq[$];
    logic [31:0] rd;
    logic [1:0]  rr;
    logic [31:0] wd;
    logic [3:0]  ws;
    int          ri;
    bit          saw_resp;

    for (int i = 0; i < NC; i++) vq.push_back('{1'b1, i, 32'(i + 1), 4'hF, 32'h0, 2'b00});
    for (int i = 0; i < NC; i++) vq.push_back('{1'b0, i, 32'h0, 4'h0, 32'(i + 1), 2'b00});
    vq.push_back('{1'b1, 2, 32'h1122_3344, 4'hF, 32'h0, 2'b00});
    vq.push_back('{1'b1, 2, 32'hAABB_CCDD, 4'b0101, 32'h0, 2'b00});
    vq.push_back('{1'b0, 2, 32'h0, 4'h0, 32'h11BB_33DD, 2'b00});
    vq.push_back('{1'b1, 2, 32'h1122_3344, 4'hF, 32'h0, 2'b00});
    vq.push_back('{1'b1, 2, 32'hAABB_CCDD, 4'b0100, 32'h0, 2'b00});
    vq.push_back('{1'b0, 2, 32'h0, 4'h0, 32'h11BB_3344, 2'b00});
    vq.push_back('{1'b1, 2, 32'hFFFF_FFFF, 4'b0000, 32'h0, 2'b00});
    vq.push_back('{1'b0, 2, 32'h0, 4'h0, 32'h11BB_3344, 2'b00});
    vq.push_back('{1'b0, 8, 32'h0, 4'h0, 32'hDEAD_BEEF, 2'b00});
    vq.push_back('{1'b1, 8, 32'h1234_5678, 4'hF, 32'h0, 2'b10});
    vq.push_back('{1'b0, 15, 32'h0, 4'h0, 32'h0, 2'b10});
    vq.push_back('{1'b0, 11, 32'h0, 4'h0, 32'hCAFE_F00D, 2'b00});
    vq.push_back('{1'b1, 13, 32'h8765_4321, 4'hF, 32'h0, 2'b10});
    vq.push_back('{1'b0, 12, 32'h0, 4'h0, 32'h0, 2'b10});

    for (int i = 0; i < NC; i++) pulse_cnt[i] = 0;
    model_reset();
    m_stat[0] = 32'hDEAD_BEEF;
    m_stat[1] = 32'h0102_0304;
    m_stat[2] = 32'hA5A5_5A5A;
    m_stat[3] = 32'hCAFE_F00D;
    push_stat();

    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_ready_valid",
                 256'({s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid}), 256'(0));
    check_output("reset_resps", 256'({s_axi_bresp, s_axi_rresp}), 256'(0));
    check_output("reset_rdata", 256'(s_axi_rdata), 256'(0));
    check_output("reset_ctrl_regs", 256'(ctrl_regs), 256'(0));
    check_output("reset_pulses", 256'(ctrl_wr_pulse), 256'(0));
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vq[k]) begin
      if (vq[k].is_write)
        do_write($sformatf("vec%0d_wr", k), vq[k].idx, vq[k].data, vq[k].strb, k % 2, (k + 1) % 3, vq[k].exp_resp);
      else
        do_read($sformatf("vec%0d_rd", k), vq[k].idx, vq[k].exp_data, vq[k].exp_resp);
    end

    do_write("aw_before_w", 5, 32'h5A5A_0005, 4'hF, 0, 3, 2'b00);
    do_write("w_before_aw", 6, 32'hA5A5_0006, 4'hF, 2, 0, 2'b00);
    do_read("aw_before_w_rb", 5, 32'h5A5A_0005, 2'b00);
    do_read("w_before_aw_rb", 6, 32'hA5A5_0006, 2'b00);

`ifdef AD9959_REGBANK_SHADOW_EN
    wd = m_live[1];
    do_write("shadow_wr", 1, 32'h0000_0055, 4'hF, 0, 0, 2'b00);
    repeat (3) @(posedge clk);
    #1;
    check_output("shadow_hold", 256'(ctrl_regs[63:32]), 256'(wd));
    do_read("shadow_rd", 1, 32'h0000_0055, 2'b00);
    commit = 1'b1;
    @(posedge clk); #1;
    commit = 1'b0;
    m_live = m_shadow;
    check_output("shadow_commit", 256'(ctrl_regs[63:32]), 256'(32'h0000_0055));
    commit = 1'b1;
    do_write("commit_same_cycle", 3, 32'h0000_0077, 4'hF, 1, 0, 2'b00);
    commit = 1'b0;
    check_output("commit_same_cycle_val", 256'(ctrl_regs[127:96]), 256'(32'h0000_0077));
`endif

    for (int n = 0; n < 40; n++) begin
      ri = int'($urandom_range(0, 15));
      m_stat[$urandom_range(0, NS - 1)] = $urandom;
      push_stat();
      if ($urandom_range(0, 1) == 1) begin
        wd = $urandom;
        ws = 4'($urandom_range(0, 15));
        do_write($sformatf("rand%0d_wr", n), ri, wd, ws,
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), (ri < NC) ? 2'b00 : 2'b10);
      end else begin
        model_read(ri, rd, rr);
        do_read($sformatf("rand%0d_rd", n), ri, rd, rr);
      end
    end

    s_axi_awaddr  = 6'h0;
    s_axi_wdata   = 32'hFFFF_FFFF;
    s_axi_wstrb   = 4'hF;
    s_axi_awvalid = 1'b1;
    s_axi_wvalid  = 1'b1;
    s_axi_araddr  = 6'h4;
    s_axi_arvalid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_output("midreset_bvalid_pre", 256'(s_axi_bvalid), 256'(1));
    check_output("midreset_rvalid_pre", 256'(s_axi_rvalid), 256'(1));
    rst_n = 1'b0;
    #1;
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
    s_axi_arvalid = 1'b0;
    check_output("midreset_valids", 256'({s_axi_bvalid, s_axi_rvalid}), 256'(0));
    check_output("midreset_ctrl_regs", 256'(ctrl_regs), 256'(0));
    model_reset();
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    saw_resp = 0;
    s_axi_bready = 1'b1;
    s_axi_rready = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      if (s_axi_bvalid || s_axi_rvalid) saw_resp = 1;
    end
    s_axi_bready = 1'b0;
    s_axi_rready = 1'b0;
    check_output("midreset_no_resp", 256'(saw_resp), 256'(0));
    check_output("midreset_ctrl_after", 256'(ctrl_regs), 256'(0));
    do_read("midreset_rd0", 0, 32'h0, 2'b00);
    do_write("midreset_wr", 4, 32'h0BAD_F00D, 4'hF, 0, 0, 2'b00);
    do_read("midreset_rd4", 4, 32'h0BAD_F00D, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
